// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states,
// the latched request and the request legality check.
package lsu_pkg;

    localparam int LSU_DEPTH = 64;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        ERR,
        RESP
    } lsu_state_e;

    // Only the fields still needed after the accepting edge are kept.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [1:0]  lane;
        logic [15:0] wdata;
    } lsu_req_t;

    function automatic logic req_is_error(input logic [1:0]  size,
                                          input logic [31:0] addr,
                                          input int unsigned depth);
        logic bad_size;
        logic misaligned;
        logic out_of_range;
        bad_size     = (size == 2'b11);
        misaligned   = ((size == SZ_HALF) && addr[0]) ||
                       ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        out_of_range = (addr >= depth * 4);
        return bad_size || misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extract+extend for loads, lane merge for
// read-modify-write sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  lane,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        load_data = word;
        merged    = word;
        byte_v    = word[{lane, 3'b000} +: 8];
        half_v    = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign & byte_v[7]}}, byte_v};
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{sign & half_v[15]}}, half_v};
                if (lane[1]) merged[31:16] = wdata;
                else         merged[15:0]  = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage in front of the word-wide data memory: one request in
// flight, registered memory interface, one response pulse per request.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH = LSU_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_dato,
    output logic [31:0] mem_direccion,
    output logic        mem_sel,
    input  logic [31:0] mem_salida
);

    lsu_state_e  state;
    lsu_req_t    req_q;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_ready = (state == IDLE);
    assign req_err   = req_is_error(req_size, req_addr, DEPTH);

    lsu_lane_align u_lane_align (
        .word      (mem_salida),
        .wdata     (req_q.wdata),
        .size      (req_q.size),
        .sign      (req_q.sign),
        .lane      (req_q.lane),
        .load_data (load_data),
        .merged    (merged)
    );

    // NOTE: all state and outputs here use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_q         <= '0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            mem_dato      <= '0;
            mem_direccion <= '0;
            mem_sel       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q         <= '{we: req_we, size: req_size, sign: req_sign,
                                           lane: req_addr[1:0], wdata: req_wdata[15:0]};
                        mem_direccion <= 32'(req_addr[IDX_W+1:2]);
                        if (req_err) begin
                            state <= ERR;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            // Word store skips the read; data must be stable while mem_sel is high.
                            mem_dato <= req_wdata;
                            mem_sel  <= 1'b1;
                            state    <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (req_q.we) begin
                        mem_dato <= merged;
                        mem_sel  <= 1'b1;
                        state    <= WR;
                    end else begin
                        rsp_rdata <= load_data;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                WR: begin
                    mem_sel   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                ERR: begin
                    rsp_err   <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64x32 memory model behind it.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_dato;
    logic [31:0] mem_direccion;
    logic        mem_sel;
    logic [31:0] mem_salida;

    logic [31:0] mem [64];
    int          wr_cnt = 0;
    int          rsp_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_sign      (req_sign),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_dato      (mem_dato),
        .mem_direccion (mem_direccion),
        .mem_sel       (mem_sel),
        .mem_salida    (mem_salida)
    );

    assign mem_salida = mem[mem_direccion[5:0]];

    always @(posedge clk) begin
        if (mem_sel) begin
            mem[mem_direccion[5:0]] <= mem_dato;
            wr_cnt       = wr_cnt + 1;
            last_wr_addr = mem_direccion;
            last_wr_data = mem_dato;
        end
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request, waits (bounded) for its response and checks the
    // response, latency, number of memory writes and the post-pulse clear.
    task automatic xact(input string tag, input logic we, input logic [1:0] size,
                        input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_writes);
        int          w0;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        w0    = wr_cnt;
        lat   = 99;
        rdata = '0;
        err   = 1'b0;
        @(negedge clk);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (rsp_valid) begin
                lat   = k;
                rdata = rsp_rdata;
                err   = rsp_err;
                break;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".rdata"}, rdata, exp_rdata);
        check({tag, ".err"}, 32'(err), 32'(exp_err));
        check({tag, ".writes"}, 32'(wr_cnt - w0), 32'(exp_writes));
        if (lat != 99) begin
            @(negedge clk);
            check({tag, ".valid_clear"}, 32'(rsp_valid), 32'd0);
            check({tag, ".rdata_clear"}, rsp_rdata, 32'd0);
            check({tag, ".err_clear"}, 32'(rsp_err), 32'd0);
        end
    endtask

    initial begin
        int          w0;
        int          r0;
        int          na;
        int          nr;
        logic        pend;
        int          acc_n [3] = '{0, 0, 0};
        int          rsp_at[3] = '{0, 0, 0};
        logic [31:0] got   [3] = '{32'h0, 32'h0, 32'h0};
        logic [31:0] bb_addr[3] = '{32'h10, 32'hFC, 32'h11};
        logic [1:0]  bb_size[3] = '{SZ_WORD, SZ_WORD, SZ_BYTE};
        logic [31:0] bb_exp [3] = '{32'hBEEFAB78, 32'h600DF00D, 32'hFFFFFFAB};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'd0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        check("rst.mem_sel", 32'(mem_sel), 32'd0);
        check("rst.mem_dato", mem_dato, 32'd0);
        check("rst.mem_direccion", mem_direccion, 32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;

        // Word store then word load
        xact("st_w_10", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0, 2, 1);
        check("st_w_10.wr_addr", last_wr_addr, 32'd4);
        check("st_w_10.wr_data", last_wr_data, 32'h12345678);
        check("st_w_10.mem4", mem[4], 32'h12345678);
        xact("ld_w_10", 1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0, 32'h12345678, 1'b0, 2, 0);

        // Sub-word stores (read-modify-write) and extending loads
        xact("st_b_11", 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h5A5A5AAB, 32'h0, 1'b0, 3, 1);
        check("st_b_11.mem4", mem[4], 32'h1234AB78);
        check("st_b_11.wr_addr", last_wr_addr, 32'd4);
        xact("ld_b_s_11", 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 32'hFFFFFFAB, 1'b0, 2, 0);
        xact("ld_b_u_11", 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 32'h000000AB, 1'b0, 2, 0);
        xact("ld_h_s_12", 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 32'h00001234, 1'b0, 2, 0);
        xact("ld_h_s_10", 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 32'hFFFFAB78, 1'b0, 2, 0);
        xact("ld_b_u_13", 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'h00000012, 1'b0, 2, 0);
        xact("st_h_12", 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h7777BEEF, 32'h0, 1'b0, 3, 1);
        check("st_h_12.mem4", mem[4], 32'hBEEFAB78);
        xact("ld_h_u_12", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'h0000BEEF, 1'b0, 2, 0);
        xact("ld_w_10_sx", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hBEEFAB78, 1'b0, 2, 0);

        // Last in-range word
        xact("st_w_fc", 1'b1, SZ_WORD, 1'b0, 32'hFC, 32'h600DF00D, 32'h0, 1'b0, 2, 1);
        check("st_w_fc.wr_addr", last_wr_addr, 32'd63);
        xact("ld_w_fc", 1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0, 32'h600DF00D, 1'b0, 2, 0);

        // Error cases
        xact("err_h_13", 1'b0, SZ_HALF, 1'b1, 32'h13, 32'h0, 32'h0, 1'b1, 2, 0);
        xact("err_w_0e", 1'b0, SZ_WORD, 1'b0, 32'h0E, 32'h0, 32'h0, 1'b1, 2, 0);
        xact("err_size", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 2, 0);
        xact("err_w_100", 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 2, 0);
        xact("err_st_w_100", 1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b1, 2, 0);
        xact("err_st_b_100", 1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h000000EE, 32'h0, 1'b1, 2, 0);
        xact("err_st_h_11", 1'b1, SZ_HALF, 1'b0, 32'h11, 32'h0000CCCC, 32'h0, 1'b1, 2, 0);
        check("err.mem4_untouched", mem[4], 32'hBEEFAB78);

        // Reset during RD of a sub-word store aborts it
        xact("st_w_20", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1);
        w0 = wr_cnt;
        r0 = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SZ_BYTE;
        req_sign  = 1'b0;
        req_addr  = 32'h21;
        req_wdata = 32'h00000011;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort.in_rd_not_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort.mem_sel_low", 32'(mem_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort.no_write", 32'(wr_cnt - w0), 32'd0);
        check("abort.no_rsp", 32'(rsp_cnt - r0), 32'd0);
        check("abort.mem8", mem[8], 32'hCAFEF00D);
        check("abort.ready", 32'(req_ready), 32'd1);

        // Back-to-back loads with req_valid held high
        na   = 0;
        nr   = 0;
        pend = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_sign  = 1'b1;
        req_addr  = bb_addr[0];
        req_size  = bb_size[0];
        for (int n = 0; n < 16; n++) begin
            if (n > 0) @(negedge clk);
            if (rsp_valid && nr < 3) begin
                got[nr]    = rsp_rdata;
                rsp_at[nr] = n;
                nr++;
            end
            if (req_valid && req_ready && na < 3) begin
                acc_n[na] = n;
                na++;
                pend = 1'b1;
            end else if (pend) begin
                pend = 1'b0;
                if (na < 3) begin
                    req_addr = bb_addr[na];
                    req_size = bb_size[na];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        check("b2b.accepts", 32'(na), 32'd3);
        check("b2b.gap01", 32'(acc_n[1] - acc_n[0]), 32'd3);
        check("b2b.gap12", 32'(acc_n[2] - acc_n[1]), 32'd3);
        check("b2b.responses", 32'(nr), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b.rdata%0d", i), got[i], bb_exp[i]);
            check($sformatf("b2b.lat%0d", i), 32'(rsp_at[i] - acc_n[i]), 32'd2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly upstream of the 64x32 word data memory. Takes byte-addressed load/store requests from the datapath and drives the memory's data, address and write-enable inputs. Performs byte and halfword lane selection, sign/zero extension and read-modify-write for sub-word stores. Checks alignment and range, and returns one response per request.

Parameters:
DEPTH, 64, number of 32-bit words in the data memory
IDX_W, 6, word-index width (log2 DEPTH)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (IDLE only)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_sign  input  1  loads: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned, out-of-range or illegal size
mem_dato  output  32  memory write data
mem_direccion  output  32  word index, zero-extended from IDX_W bits
mem_sel  output  1  memory write enable (1 = write)
mem_salida  input  32  memory read data, combinational from mem_direccion

Behaviour:
- Reset (async, rst_n=0): state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_sel=0, mem_dato=0, mem_direccion=0. Reset mid-operation aborts the request with no response. mem_sel falls immediately, so a pending RMW write never happens.
- All mem_* outputs are registered. mem_direccion and mem_dato are stable for the whole cycle in which mem_sel=1.
- req_ready=1 only in IDLE. Accept = req_valid & req_ready. The request is latched on the accepting edge.
- Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1]; word index = addr[IDX_W+1:2].
- Error if any of: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr >= DEPTH*4. An errored request makes no memory write.
- States:
  - IDLE: on accept go to ERR if the request is an error. Otherwise go to RD for a load or a sub-word store, or WR for a word store. Load mem_direccion with the word index on that edge.
  - RD: mem_sel=0. Capture mem_salida at end of cycle. Load -> RESP. Sub-word store -> WR, with mem_dato = captured word and the selected lane(s) replaced by req_wdata[7:0] or [15:0].
  - WR: mem_sel=1 for exactly one cycle; mem_dato = req_wdata for word stores. Next state RESP.
  - ERR: next state RESP with rsp_err=1.
  - RESP: rsp_valid=1 for one cycle, no backpressure. Next state IDLE, where a new accept is allowed in the same cycle that follows.
- Load data: extract the lane, then extend to 32 bits per req_sign. Word loads ignore req_sign.
- Latency from accept edge T to rsp_valid:
  - load: T+2
  - word store: T+2
  - sub-word store: T+3
  - error: T+2 (through ERR)
- rsp_rdata and rsp_err hold their value only while rsp_valid=1 and return to 0 afterwards.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package lsu_pkg holds:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state encoding IDLE/RD/WR/ERR/RESP
  - DEPTH default
- One combinational sub-module, lsu_lane_align: extract+extend for loads, merge for sub-word stores.

Test Plan:
- Word store 0x12345678 to addr 0x10, then word load of 0x10 -> mem_sel high exactly one cycle with mem_direccion=4; load returns 0x12345678 at T+2, rsp_err=0.
- Byte store 0xAB to addr 0x11 over word 0x12345678 -> RD then WR; memory word 4 becomes 0x1234AB78; rsp_valid at T+3.
- Signed byte load of addr 0x11 (word 0x1234AB78) -> 0xFFFFFFAB; unsigned -> 0x000000AB. Signed half load of addr 0x12 -> 0x00001234.
- Half load at addr 0x13, word load at 0x0E, size=11, and word load at 0x100 -> each gives rsp_err=1 at T+2, rsp_rdata=0, no mem_sel pulse.
- Sub-word store accepted, then rst_n pulsed low during RD -> no mem_sel pulse, no rsp_valid; memory word unchanged; req_ready=1 after release.
- Back-to-back loads with req_valid held high -> requests accepted every 3 cycles; responses arrive in order with correct data.
